// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the PCIe->Aurora command framer.
// Frame: {sync, length} header, payload words, XOR trailer.
package cmd_frame_pkg;

    localparam int WORD_W = 32;
    localparam logic [15:0] HDR_SYNC = 16'hA55A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        TRL  = 2'd3
    } state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry fall-through FIFO hiding the RX FIFO read latency.
// Data arriving while empty and drained in the same cycle bypasses storage.
module axis_skid_buf
    import cmd_frame_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   level
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic         empty;
    logic         bypass;
    logic         push;
    logic         pop_mem;

    assign empty     = (cnt == 2'd0);
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : mem[rd_ptr];
    assign bypass    = empty && in_valid && out_ready;
    assign push      = in_valid && !bypass;
    assign pop_mem   = !empty && out_ready;
    assign level     = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_mem) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop_mem};
        end
    end

endmodule

// File: rtl/cmd_frame_tx.sv
// Transmit framer: drains RX FIFO command words into framed AXI-Stream
// packets (header, payload, XOR trailer) for the Aurora TX port.
module cmd_frame_tx
    import cmd_frame_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_W     = 13
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              link_up,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_rd_en,
    output logic [WORD_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [15:0]       frame_cnt,
    output logic              busy
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [15:0] MAX_L = 16'(MAX_WORDS);

    state_t             state;
    state_t             state_nx;
    logic [15:0]        len;
    logic [15:0]        len_nx;
    logic [15:0]        rd_issued;
    logic [15:0]        pay_cnt;
    logic [WORD_W-1:0]  csum;
    logic [TMO_W-1:0]   tmo;
    logic               in_flight;
    logic [31:0]        cnt_w;
    logic               full;
    logic               tmo_hit;
    logic               start;
    logic               pay_beat;
    logic               sk_valid;
    logic [WORD_W-1:0]  sk_data;
    logic               sk_ready;
    logic [1:0]         sk_level;
    logic [2:0]         occ;

    assign cnt_w    = 32'(fifo_count);
    assign full     = cnt_w >= 32'(MAX_WORDS);
    assign tmo_hit  = (tmo == TMO_W'(TIMEOUT - 1)) && !fifo_empty;
    assign start    = (state == IDLE) && link_up && (full || tmo_hit);
    assign len_nx   = full ? MAX_L
                    : (cnt_w == 32'd0) ? 16'd1 : cnt_w[15:0];
    assign pay_beat = (state == PAY) && sk_valid && m_axis_tready;
    assign busy     = (state != IDLE);

    // Skid entries plus the read in flight must never exceed two.
    assign occ = {1'b0, sk_level} + {2'b00, in_flight};
    assign fifo_rd_en = ((state == HDR) || (state == PAY))
                     && !fifo_empty
                     && (rd_issued < len)
                     && (occ < 3'd2);

    axis_skid_buf #(.W(WORD_W)) u_skid (
        .clk       (clkin),
        .rst       (reset),
        .in_valid  (in_flight),
        .in_data   (fifo_dout),
        .out_valid (sk_valid),
        .out_data  (sk_data),
        .out_ready (sk_ready),
        .level     (sk_level)
    );

    always_comb begin
        state_nx      = state;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        sk_ready      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = HDR;
            end
            HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {HDR_SYNC, len};
                if (m_axis_tready) state_nx = PAY;
            end
            PAY: begin
                m_axis_tvalid = sk_valid;
                m_axis_tdata  = sk_data;
                sk_ready      = m_axis_tready;
                if (pay_beat && (pay_cnt == len - 16'd1)) state_nx = TRL;
            end
            TRL: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tdata  = csum;
                if (m_axis_tready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len       <= 16'd0;
            rd_issued <= 16'd0;
            pay_cnt   <= 16'd0;
            csum      <= '0;
            tmo       <= '0;
            in_flight <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            state     <= state_nx;
            in_flight <= fifo_rd_en;
            if (start) begin
                len       <= len_nx;
                rd_issued <= 16'd0;
                pay_cnt   <= 16'd0;
            end else if (fifo_rd_en) begin
                rd_issued <= rd_issued + 16'd1;
            end
            if (pay_beat) begin
                pay_cnt <= pay_cnt + 16'd1;
                csum    <= csum ^ sk_data;
            end
            if ((state == TRL) && m_axis_tready) begin
                frame_cnt <= frame_cnt + 16'd1;
                csum      <= '0;
            end
            if (start || fifo_empty || !link_up) begin
                tmo <= '0;
            end else if ((state == IDLE) && !full) begin
                tmo <= tmo + 1'b1;
            end
        end
    end

endmodule
